rmon_counter_ctrl: RTL and testbench

//  Read-modify-write engine driving port-a of the 64x32 RMON statistics RAM.

---
 rtl/rmon_counter_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_rmon_counter_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rmon_counter_ctrl.sv
// Read-modify-write engine for port-a of the RMON statistics RAM: round-robin Rx/Tx
// counter updates plus a clear-all sweep. Define RMON_SATURATE_EN for saturating sums.
module rmon_counter_ctrl #(
    parameter int ADDR_W  = 6,
    parameter int DELTA_W = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Rx_apply,
    input  logic [ADDR_W-2:0]  Rx_cnt_id,
    input  logic [DELTA_W-1:0] Rx_delta,
    input  logic               Tx_apply,
    input  logic [ADDR_W-2:0]  Tx_cnt_id,
    input  logic [DELTA_W-1:0] Tx_delta,
    input  logic               Clr_req,
    output logic               Clr_busy,
    output logic               Rx_ovf,
    output logic               Tx_ovf,
    output logic [ADDR_W-1:0]  Addra,
    output logic [31:0]        Dina,
    input  logic [31:0]        Douta,
    output logic               Wea,
    output logic [2:0]         Dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WT   = 3'd2,
        S_WR   = 3'd3,
        S_CLR  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_rx_vld;
    logic [ADDR_W-2:0]    r_rx_id;
    logic [DELTA_W-1:0]   r_rx_delta;
    logic                 r_tx_vld;
    logic [ADDR_W-2:0]    r_tx_id;
    logic [DELTA_W-1:0]   r_tx_delta;
    logic                 r_last_tx;
    logic [DELTA_W-1:0]   r_delta;
    logic [ADDR_W-1:0]    r_addr;
    logic [31:0]          r_dina;
    logic                 r_wea;
    logic                 r_clr_busy;
    logic                 r_rx_ovf;
    logic                 r_tx_ovf;
    logic                 w_grant_rx;
    logic                 w_grant_tx;
    logic                 w_clr_entry;
    logic [31:0]          w_sum;

    assign w_clr_entry = (r_state == S_IDLE) && r_clr_busy;

`ifdef RMON_SATURATE_EN
    logic [32:0] w_sum_ext;
    assign w_sum_ext = {1'b0, Douta} + {{(33-DELTA_W){1'b0}}, r_delta};
    assign w_sum     = w_sum_ext[32] ? 32'hFFFF_FFFF : w_sum_ext[31:0];
`else
    assign w_sum = Douta + {{(32-DELTA_W){1'b0}}, r_delta};
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // A pending clear outranks any pending event; both pending alternate on r_last_tx.
    always_comb begin
        w_next_state = r_state;
        w_grant_rx   = 1'b0;
        w_grant_tx   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_clr_busy) begin
                    w_next_state = S_CLR;
                end else if (r_rx_vld && r_tx_vld) begin
                    w_grant_rx   = r_last_tx;
                    w_grant_tx   = !r_last_tx;
                    w_next_state = S_RD;
                end else if (r_rx_vld) begin
                    w_grant_rx   = 1'b1;
                    w_next_state = S_RD;
                end else if (r_tx_vld) begin
                    w_grant_tx   = 1'b1;
                    w_next_state = S_RD;
                end
            end
            S_RD:    w_next_state = S_WT;
            S_WT:    w_next_state = S_WR;
            S_WR:    w_next_state = S_IDLE;
            S_CLR:   if (r_addr == ADDR_LAST) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_rx_vld   <= 1'b0;
            r_rx_id    <= '0;
            r_rx_delta <= '0;
            r_rx_ovf   <= 1'b0;
        end else if (w_clr_entry) begin
            r_rx_vld <= 1'b0;
            r_rx_ovf <= 1'b0;
        end else if (Rx_apply) begin
            if (r_rx_vld && !w_grant_rx) begin
                r_rx_ovf <= 1'b1;
            end else begin
                r_rx_vld   <= 1'b1;
                r_rx_id    <= Rx_cnt_id;
                r_rx_delta <= Rx_delta;
            end
        end else if (w_grant_rx) begin
            r_rx_vld <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_tx_vld   <= 1'b0;
            r_tx_id    <= '0;
            r_tx_delta <= '0;
            r_tx_ovf   <= 1'b0;
        end else if (w_clr_entry) begin
            r_tx_vld <= 1'b0;
            r_tx_ovf <= 1'b0;
        end else if (Tx_apply) begin
            if (r_tx_vld && !w_grant_tx) begin
                r_tx_ovf <= 1'b1;
            end else begin
                r_tx_vld   <= 1'b1;
                r_tx_id    <= Tx_cnt_id;
                r_tx_delta <= Tx_delta;
            end
        end else if (w_grant_tx) begin
            r_tx_vld <= 1'b0;
        end
    end

    // RAM port-a drive; the sweep holds Wea high while Addra walks 0..ADDR_LAST.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_addr    <= '0;
            r_dina    <= '0;
            r_wea     <= 1'b0;
            r_delta   <= '0;
            r_last_tx <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_clr_entry) begin
                        r_addr <= '0;
                        r_dina <= '0;
                        r_wea  <= 1'b1;
                    end else if (w_grant_rx) begin
                        r_addr    <= {1'b0, r_rx_id};
                        r_delta   <= r_rx_delta;
                        r_last_tx <= 1'b0;
                    end else if (w_grant_tx) begin
                        r_addr    <= {1'b1, r_tx_id};
                        r_delta   <= r_tx_delta;
                        r_last_tx <= 1'b1;
                    end
                end
                S_WT: begin
                    r_dina <= w_sum;
                    r_wea  <= 1'b1;
                end
                S_WR: r_wea <= 1'b0;
                S_CLR: begin
                    if (r_addr == ADDR_LAST) r_wea  <= 1'b0;
                    else                     r_addr <= r_addr + ADDR_ONE;
                end
                default: r_wea <= 1'b0;
            endcase
        end
    end

    // Requests arriving during the sweep are ignored, not queued.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)                                          r_clr_busy <= 1'b0;
        else if ((r_state == S_CLR) && (r_addr == ADDR_LAST)) r_clr_busy <= 1'b0;
        else if (Clr_req && (r_state != S_CLR))              r_clr_busy <= 1'b1;
    end

    assign Addra     = r_addr;
    assign Dina      = r_dina;
    assign Wea       = r_wea;
    assign Clr_busy  = r_clr_busy;
    assign Rx_ovf    = r_rx_ovf;
    assign Tx_ovf    = r_tx_ovf;
    assign Dbg_state = r_state;

endmodule

// File: tb/tb_rmon_counter_ctrl.sv
// Directed bench for rmon_counter_ctrl with a behavioural 64x32 RAM on port-a.
module tb_rmon_counter_ctrl;
    localparam int ADDR_W  = 6;
    localparam int DELTA_W = 16;

    logic               Clk = 1'b0;
    logic               Reset;
    logic               Rx_apply;
    logic [ADDR_W-2:0]  Rx_cnt_id;
    logic [DELTA_W-1:0] Rx_delta;
    logic               Tx_apply;
    logic [ADDR_W-2:0]  Tx_cnt_id;
    logic [DELTA_W-1:0] Tx_delta;
    logic               Clr_req;
    logic               Clr_busy;
    logic               Rx_ovf;
    logic               Tx_ovf;
    logic [ADDR_W-1:0]  Addra;
    logic [31:0]        Dina;
    logic [31:0]        Douta;
    logic               Wea;
    logic [2:0]         Dbg_state;

    logic [31:0]        mem [64];
    logic               ld_en;
    logic [ADDR_W-1:0]  ld_addr;
    logic [31:0]        ld_data;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 Clk = ~Clk;

    rmon_counter_ctrl #(.ADDR_W(ADDR_W), .DELTA_W(DELTA_W)) dut (
        .Clk(Clk), .Reset(Reset),
        .Rx_apply(Rx_apply), .Rx_cnt_id(Rx_cnt_id), .Rx_delta(Rx_delta),
        .Tx_apply(Tx_apply), .Tx_cnt_id(Tx_cnt_id), .Tx_delta(Tx_delta),
        .Clr_req(Clr_req), .Clr_busy(Clr_busy), .Rx_ovf(Rx_ovf), .Tx_ovf(Tx_ovf),
        .Addra(Addra), .Dina(Dina), .Douta(Douta), .Wea(Wea), .Dbg_state(Dbg_state)
    );

    // Synchronous RAM: address sampled on the edge, data available the next cycle.
    always @(posedge Clk) begin
        if (ld_en)    mem[ld_addr] <= ld_data;
        else if (Wea) mem[Addra]   <= Dina;
        Douta <= mem[Addra];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else             n_pass++;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic ram_load(input int a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = ADDR_W'(a);
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    task automatic do_reset();
        Reset    = 1'b0;
        Rx_apply = 1'b0; Rx_cnt_id = '0; Rx_delta = '0;
        Tx_apply = 1'b0; Tx_cnt_id = '0; Tx_delta = '0;
        Clr_req  = 1'b0;
        ticks(2);
        Reset = 1'b1;
    endtask

    task automatic rx_set(input int id, input int d);
        Rx_apply  = 1'b1;
        Rx_cnt_id = (ADDR_W-1)'(id);
        Rx_delta  = DELTA_W'(d);
    endtask

    task automatic tx_set(input int id, input int d);
        Tx_apply  = 1'b1;
        Tx_cnt_id = (ADDR_W-1)'(id);
        Tx_delta  = DELTA_W'(d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_wrap;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        do_reset();
        Reset = 1'b0;
        for (int a = 0; a < 64; a++) ram_load(a, 32'h0);

        // Reset values while held in reset
        check_eq("rst_addra", Addra, 0);
        check_eq("rst_dina", Dina, 0);
        check_eq("rst_wea", Wea, 0);
        check_eq("rst_clr_busy", Clr_busy, 0);
        check_eq("rst_rx_ovf", Rx_ovf, 0);
        check_eq("rst_tx_ovf", Tx_ovf, 0);
        check_eq("rst_state", Dbg_state, 0);

        // Single Rx increment: RAM[3]=5, +1
        do_reset();
        ram_load(3, 32'd5);
        rx_set(3, 1); tick(); Rx_apply = 1'b0;
        check_eq("t1_addra_e0", Addra, 0);
        tick();
        check_eq("t1_addra_e1", Addra, 3);
        check_eq("t1_wea_e1", Wea, 0);
        ticks(2);
        check_eq("t1_wea_e3", Wea, 1);
        check_eq("t1_dina_e3", Dina, 6);
        tick();
        check_eq("t1_wea_e4", Wea, 0);
        check_eq("t1_ram3", mem[3], 6);
        check_eq("t1_state", Dbg_state, 0);

        // Simultaneous Rx/Tx: Rx first after reset, Tx next
        do_reset();
        ram_load(2, 32'd0); ram_load(34, 32'd0);
        rx_set(2, 64); tx_set(2, 100); tick(); Rx_apply = 1'b0; Tx_apply = 1'b0;
        tick();
        check_eq("t2_addra_rx", Addra, 2);
        ticks(2);
        check_eq("t2_dina_rx", Dina, 64);
        tick();
        check_eq("t2_ram2", mem[2], 64);
        tick();
        check_eq("t2_addra_tx", Addra, 34);
        ticks(2);
        check_eq("t2_dina_tx", Dina, 100);
        check_eq("t2_wea_tx", Wea, 1);
        tick();
        check_eq("t2_ram34", mem[34], 100);
        check_eq("t2_wea_end", Wea, 0);

        // Rx burst during a Tx RMW: first held, later ones dropped
        do_reset();
        ram_load(10, 32'd7); ram_load(37, 32'd0);
        tx_set(5, 1); tick(); Tx_apply = 1'b0;
        rx_set(10, 3); tick();
        check_eq("t3_addra_tx", Addra, 37);
        check_eq("t3_rx_ovf_e1", Rx_ovf, 0);
        rx_set(10, 5); tick();
        check_eq("t3_rx_ovf_e2", Rx_ovf, 1);
        rx_set(10, 9); tick(); Rx_apply = 1'b0;
        check_eq("t3_tx_ovf", Tx_ovf, 0);
        check_eq("t3_dina_tx", Dina, 1);
        tick();
        check_eq("t3_ram37", mem[37], 1);
        tick();
        check_eq("t3_addra_rx", Addra, 10);
        ticks(2);
        check_eq("t3_dina_rx", Dina, 10);
        ticks(5);
        check_eq("t3_ram10", mem[10], 10);
        check_eq("t3_addra_idle", Addra, 10);
        check_eq("t3_rx_ovf_sticky", Rx_ovf, 1);

        // Apply during own grant cycle is accepted; back-to-back RMW on same counter
        do_reset();
        ram_load(1, 32'd100);
        rx_set(1, 2); tick();
        rx_set(1, 5); tick(); Rx_apply = 1'b0;
        check_eq("t3b_rx_ovf", Rx_ovf, 0);
        ticks(3);
        check_eq("t3b_ram1_first", mem[1], 102);
        tick();
        check_eq("t3b_addra_second", Addra, 1);
        ticks(3);
        check_eq("t3b_ram1_second", mem[1], 107);
        check_eq("t3b_rx_ovf_end", Rx_ovf, 0);

        // 32-bit overflow of a Tx counter
`ifdef RMON_SATURATE_EN
        exp_wrap = 32'hFFFF_FFFF;
`else
        exp_wrap = 32'h0000_0010;
`endif
        do_reset();
        ram_load(40, 32'hFFFF_FFF0);
        tx_set(8, 32); tick(); Tx_apply = 1'b0;
        tick();
        check_eq("t4_addra", Addra, 40);
        ticks(2);
        check_eq("t4_dina", Dina, exp_wrap);
        tick();
        check_eq("t4_ram40", mem[40], exp_wrap);

        // Clear requested mid-RMW
        do_reset();
        ram_load(20, 32'd50); ram_load(63, 32'd123); ram_load(4, 32'd44); ram_load(35, 32'd0);
        rx_set(20, 1); tick(); Rx_apply = 1'b0;
        tx_set(3, 1); tick();
        check_eq("t5_clr_busy_pre", Clr_busy, 0);
        Clr_req = 1'b1; tick(); Tx_apply = 1'b0; Clr_req = 1'b0;
        check_eq("t5_clr_busy_set", Clr_busy, 1);
        check_eq("t5_tx_ovf_set", Tx_ovf, 1);
        tick();
        check_eq("t5_dina_rmw", Dina, 51);
        check_eq("t5_wea_rmw", Wea, 1);
        tick();
        check_eq("t5_ram20_rmw", mem[20], 51);
        check_eq("t5_state_idle", Dbg_state, 0);
        tick();
        check_eq("t5_clr_state", Dbg_state, 4);
        check_eq("t5_clr_addra0", Addra, 0);
        check_eq("t5_clr_dina0", Dina, 0);
        check_eq("t5_clr_wea0", Wea, 1);
        check_eq("t5_tx_ovf_cleared", Tx_ovf, 0);
        for (int k = 1; k < 64; k++) begin
            if (k == 10) Clr_req = 1'b1;
            if (k == 20) rx_set(4, 9);
            tick();
            Clr_req  = 1'b0;
            Rx_apply = 1'b0;
            check_eq($sformatf("t5_sweep_addra_%0d", k), Addra, k);
            check_eq($sformatf("t5_sweep_wea_%0d", k), Wea, 1);
        end
        tick();
        check_eq("t5_exit_wea", Wea, 0);
        check_eq("t5_exit_clr_busy", Clr_busy, 0);
        check_eq("t5_exit_state", Dbg_state, 0);
        check_eq("t5_ram63", mem[63], 0);
        check_eq("t5_ram20", mem[20], 0);
        check_eq("t5_ram4_cleared", mem[4], 0);
        tick();
        check_eq("t5_post_addra", Addra, 4);
        check_eq("t5_post_clr_busy", Clr_busy, 0);
        ticks(2);
        check_eq("t5_post_dina", Dina, 9);
        tick();
        check_eq("t5_post_ram4", mem[4], 9);
        ticks(4);
        check_eq("t5_post_wea", Wea, 0);
        check_eq("t5_post_state", Dbg_state, 0);
        check_eq("t5_ram35_untouched", mem[35], 0);
        check_eq("t5_post_clr_busy2", Clr_busy, 0);

        // Reset during WT abandons the update
        do_reset();
        ram_load(12, 32'd77);
        rx_set(12, 1); tick(); Rx_apply = 1'b0;
        ticks(2);
        check_eq("t6_state_wt", Dbg_state, 2);
        #2 Reset = 1'b0;
        #1;
        check_eq("t6_async_wea", Wea, 0);
        check_eq("t6_async_addra", Addra, 0);
        check_eq("t6_async_state", Dbg_state, 0);
        tick();
        check_eq("t6_edge_wea", Wea, 0);
        check_eq("t6_edge_dina", Dina, 0);
        Reset = 1'b1;
        ticks(4);
        check_eq("t6_ram12", mem[12], 77);
        check_eq("t6_wea_after", Wea, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
